// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
//
// Sequential single-neuron multiply-accumulate engine. After START it streams
// N_IN signed activations from X (valid/ready), multiplies each by the weight
// read from an external synchronous RAM, adds the bias stored at address N_IN
// (scaled into the accumulator's fixed-point position), then rescales,
// saturates and presents the 16-bit result on Y (valid/ready).
//
// Ports:
//   CLK, RST          clock (rising edge) and asynchronous active-high reset
//   START / BUSY      begin an evaluation (sampled in IDLE) / engine occupied
//   X_DATA/X_VALID/X_READY  signed activation stream input
//   W_ADDR/W_EN/W_WE/W_DI   weight RAM control (read-only: WE and DI tied 0)
//   W_DO              weight RAM read data, updated by the RAM on falling CLK
//   Y_DATA/Y_VALID/Y_READY  signed neuron result output
//
// Configuration macro:
//   NEURON_RELU_EN    when defined, negative saturated results are output as 0.

module neuron_mac_seq #(
    parameter int N_IN      = 27,
    parameter int FRAC_BITS = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               BUSY,
    input  logic signed [15:0] X_DATA,
    input  logic               X_VALID,
    output logic               X_READY,
    output logic [4:0]         W_ADDR,
    output logic               W_EN,
    output logic               W_WE,
    output logic [15:0]        W_DI,
    input  logic signed [15:0] W_DO,
    output logic signed [15:0] Y_DATA,
    output logic               Y_VALID,
    input  logic               Y_READY
);

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        RUN,
        BIAS,
        OUT
    } state_t;

    localparam logic [4:0] LAST_K    = 5'(N_IN - 1);
    localparam logic [4:0] BIAS_ADDR = 5'(N_IN);

    state_t             state_q, state_d;
    logic signed [39:0] acc_q, acc_d;
    logic [4:0]         k_q, k_d;
    logic [4:0]         w_addr_q, w_addr_d;
    logic               w_en_q, w_en_d;
    logic               x_ready_q, x_ready_d;
    logic               y_valid_q, y_valid_d;
    logic signed [15:0] y_data_q, y_data_d;
    logic               busy_q, busy_d;

    logic signed [31:0] x_ext, w_ext, product;
    logic signed [39:0] product_ext;
    logic signed [39:0] bias_term;
    logic signed [39:0] bias_sum;
    logic signed [39:0] shifted;
    logic signed [15:0] result;

    // Datapath: the product of two 16-bit signed values always fits in 32
    // bits, so the low 32 bits of the widened multiply are the exact product.
    always_comb begin
        x_ext       = {{16{X_DATA[15]}}, X_DATA};
        w_ext       = {{16{W_DO[15]}}, W_DO};
        product     = x_ext * w_ext;
        product_ext = {{8{product[31]}}, product};
        bias_term   = {{24{W_DO[15]}}, W_DO} <<< FRAC_BITS;
        bias_sum    = acc_q + bias_term;
        shifted     = bias_sum >>> FRAC_BITS;
        if (shifted > 40'sd32767) begin
            result = 16'sh7FFF;
        end else if (shifted < -40'sd32768) begin
            result = 16'sh8000;
        end else begin
            result = shifted[15:0];
        end
`ifdef NEURON_RELU_EN
        if (result[15]) begin
            result = 16'sh0000;
        end
`endif
    end

    // Next-state logic. W_ADDR tracks k so that the RAM, reading on the
    // falling edge, always presents the weight of the next input to accept.
    // W_EN stays high through BIAS so the bias word is fetched, and drops on
    // the edge that leaves BIAS.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        k_d       = k_q;
        w_addr_d  = w_addr_q;
        w_en_d    = w_en_q;
        x_ready_d = x_ready_q;
        y_valid_d = y_valid_q;
        y_data_d  = y_data_q;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    acc_d    = '0;
                    k_d      = '0;
                    w_addr_d = '0;
                    w_en_d   = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = PRIME;
                end
            end
            PRIME: begin
                x_ready_d = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (X_VALID && x_ready_q) begin
                    acc_d    = acc_q + product_ext;
                    k_d      = k_q + 5'd1;
                    w_addr_d = k_q + 5'd1;
                    if (k_q == LAST_K) begin
                        w_addr_d  = BIAS_ADDR;
                        x_ready_d = 1'b0;
                        state_d   = BIAS;
                    end
                end
            end
            BIAS: begin
                acc_d     = bias_sum;
                w_en_d    = 1'b0;
                y_data_d  = result;
                y_valid_d = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (Y_READY) begin
                    y_valid_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All state, including every control output, is registered here.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            k_q       <= '0;
            w_addr_q  <= '0;
            w_en_q    <= 1'b0;
            x_ready_q <= 1'b0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            w_addr_q  <= w_addr_d;
            w_en_q    <= w_en_d;
            x_ready_q <= x_ready_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            busy_q    <= busy_d;
        end
    end

    assign BUSY    = busy_q;
    assign X_READY = x_ready_q;
    assign W_ADDR  = w_addr_q;
    assign W_EN    = w_en_q;
    assign W_WE    = 1'b0;
    assign W_DI    = 16'h0000;
    assign Y_DATA  = y_data_q;
    assign Y_VALID = y_valid_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// tb_neuron_mac_seq
//
// Testbench for neuron_mac_seq. Models the weight RAM (read on falling CLK),
// streams activations with optional random gaps, and compares results with an
// arithmetic reference of the neuron: floor((sum x*w + bias*2^F) / 2^F),
// saturated to 16 bits, optionally clipped at zero when NEURON_RELU_EN is set.

module tb_neuron_mac_seq;

    localparam int N_IN = 27;
    localparam int FRAC = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic        BUSY;
    logic [15:0] X_DATA;
    logic        X_VALID;
    logic        X_READY;
    logic [4:0]  W_ADDR;
    logic        W_EN;
    logic        W_WE;
    logic [15:0] W_DI;
    logic [15:0] W_DO;
    logic [15:0] Y_DATA;
    logic        Y_VALID;
    logic        Y_READY;

    logic [15:0] ram [32];
    logic [15:0] xs  [N_IN];
    int checks = 0;
    int errors = 0;

    neuron_mac_seq #(.N_IN(N_IN), .FRAC_BITS(FRAC)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY),
        .X_DATA(X_DATA), .X_VALID(X_VALID), .X_READY(X_READY),
        .W_ADDR(W_ADDR), .W_EN(W_EN), .W_WE(W_WE), .W_DI(W_DI), .W_DO(W_DO),
        .Y_DATA(Y_DATA), .Y_VALID(Y_VALID), .Y_READY(Y_READY)
    );

    always #5 CLK = ~CLK;

    // Weight RAM: enabled read, data appears on the falling edge.
    initial W_DO = 16'h0000;
    always @(negedge CLK) if (W_EN) W_DO <= ram[W_ADDR];

    // Reference neuron computed from the arithmetic definition.
    function automatic logic [15:0] model_y();
        longint acc = 0;
        for (int i = 0; i < N_IN; i++)
            acc += longint'($signed(xs[i])) * longint'($signed(ram[i]));
        acc += longint'($signed(ram[N_IN])) * (longint'(1) <<< FRAC);
        acc = acc >>> FRAC;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef NEURON_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return 16'(acc);
    endfunction

    function automatic void fill(input logic [15:0] w, input logic [15:0] b, input logic [15:0] x);
        for (int i = 0; i < N_IN; i++) begin
            ram[i] = w;
            xs[i]  = x;
        end
        ram[N_IN] = b;
    endfunction

    // Pulse START for one edge (optionally leave it high afterwards).
    task automatic start_eval(input bit hold_start);
        START = 1'b1;
        @(posedge CLK); #1;
        if (!hold_start) START = 1'b0;
    endtask

    // Stream xs[0..n-1] through the handshake; ends 1 time unit after the
    // edge that accepted the last value.
    task automatic stream_inputs(input bit gaps, input int n);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        while (idx < n && cyc < 400) begin
            X_VALID = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            X_DATA  = X_VALID ? xs[idx] : 16'($urandom);
            @(negedge CLK);
            acc = X_VALID && X_READY;
            @(posedge CLK); #1;
            if (acc) idx++;
            cyc++;
        end
        X_VALID = 1'b0;
        if (idx < n) begin
            checks++; errors++;
            $display("[TB] FAIL stream_timeout accepted %0d required %0d", idx, n);
        end
    endtask

    // Wait (bounded) for Y_VALID, counting falling edges; ends on a falling edge.
    task automatic wait_result(output logic [15:0] y, output int lat);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
        end while (!Y_VALID && lat < 20);
        y = Y_DATA;
        if (!Y_VALID) begin
            checks++; errors++;
            $display("[TB] FAIL result_timeout no Y_VALID within %0d cycles", lat);
        end
    endtask

    // Consume the result; called on a falling edge, ends after the next rise.
    task automatic release_result(input bit start_too);
        Y_READY = 1'b1;
        START   = start_too;
        @(posedge CLK); #1;
        Y_READY = 1'b0;
        START   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (X_READY !== 1'b0)  begin errors++; $display("[TB] FAIL reset_xready got %b want 0", X_READY); end
        checks++; if (W_ADDR !== 5'd0)   begin errors++; $display("[TB] FAIL reset_waddr got %0d want 0", W_ADDR); end
        checks++; if (W_EN !== 1'b0)     begin errors++; $display("[TB] FAIL reset_wen got %b want 0", W_EN); end
        checks++; if (Y_VALID !== 1'b0)  begin errors++; $display("[TB] FAIL reset_yvalid got %b want 0", Y_VALID); end
        checks++; if (Y_DATA !== 16'h0)  begin errors++; $display("[TB] FAIL reset_ydata got %h want 0000", Y_DATA); end
        checks++; if ({W_WE, W_DI} !== 17'h0) begin errors++; $display("[TB] FAIL reset_write got %b/%h want 0/0000", W_WE, W_DI); end
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_ones();
        logic [15:0] y;
        int lat;
        fill(16'h0100, 16'h0000, 16'h0100);
        start_eval(1'b0);
        @(negedge CLK);
        checks++; if (X_READY !== 1'b0) begin errors++; $display("[TB] FAIL prime_xready got %b want 0", X_READY); end
        checks++; if (BUSY !== 1'b1)    begin errors++; $display("[TB] FAIL prime_busy got %b want 1", BUSY); end
        checks++; if (W_EN !== 1'b1)    begin errors++; $display("[TB] FAIL prime_wen got %b want 1", W_EN); end
        @(negedge CLK);
        checks++; if (X_READY !== 1'b1) begin errors++; $display("[TB] FAIL run_xready_latency got %b want 1", X_READY); end
        @(posedge CLK); #1;
        stream_inputs(1'b0, N_IN);
        checks++; if (W_ADDR !== 5'(N_IN)) begin errors++; $display("[TB] FAIL bias_addr got %0d want %0d", W_ADDR, N_IN); end
        checks++; if (X_READY !== 1'b0)    begin errors++; $display("[TB] FAIL bias_xready got %b want 0", X_READY); end
        wait_result(y, lat);
        checks++; if (lat !== 2)        begin errors++; $display("[TB] FAIL y_latency got %0d want 2", lat); end
        checks++; if (y !== 16'h1B00)   begin errors++; $display("[TB] FAIL ones_y got %h want 1b00", y); end
        checks++; if (W_EN !== 1'b0)    begin errors++; $display("[TB] FAIL out_wen got %b want 0", W_EN); end
        checks++; if (BUSY !== 1'b1)    begin errors++; $display("[TB] FAIL out_busy got %b want 1", BUSY); end
        release_result(1'b0);
    endtask

    task automatic test_negative();
        logic [15:0] y, want;
        int lat;
        fill(16'hFF00, 16'h0000, 16'h0100);
`ifdef NEURON_RELU_EN
        want = 16'h0000;
`else
        want = 16'hE500;
`endif
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== want) begin errors++; $display("[TB] FAIL negative_y got %h want %h", y, want); end
        release_result(1'b0);
    endtask

    task automatic test_saturation();
        logic [15:0] y, want;
        int lat;
        fill(16'h7FFF, 16'h0000, 16'h7FFF);
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== 16'h7FFF) begin errors++; $display("[TB] FAIL sat_pos got %h want 7fff", y); end
        release_result(1'b0);
        fill(16'h8000, 16'h0000, 16'h7FFF);
`ifdef NEURON_RELU_EN
        want = 16'h0000;
`else
        want = 16'h8000;
`endif
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== want) begin errors++; $display("[TB] FAIL sat_neg got %h want %h", y, want); end
        release_result(1'b0);
    endtask

    task automatic test_bias_gaps();
        logic [15:0] y, y2, want;
        int lat;
        fill(16'h1234, 16'h0280, 16'h0000);
        start_eval(1'b0);
        stream_inputs(1'b1, N_IN);
        wait_result(y, lat);
        checks++; if (y !== 16'h0280) begin errors++; $display("[TB] FAIL bias_only got %h want 0280", y); end
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            checks++;
            if (Y_DATA !== y || Y_VALID !== 1'b1) begin
                errors++;
                $display("[TB] FAIL hold_stable cycle %0d got %h/%b want %h/1", c, Y_DATA, Y_VALID, y);
            end
        end
        release_result(1'b0);
        // Same random data with and without gaps must agree with the model.
        for (int i = 0; i < N_IN; i++) begin
            ram[i] = 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
            xs[i]  = 16'($signed(16'($urandom_range(0, 1023))) - 16'sd512);
        end
        ram[N_IN] = 16'($urandom_range(0, 511));
        want = model_y();
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        release_result(1'b0);
        start_eval(1'b0);
        stream_inputs(1'b1, N_IN);
        wait_result(y2, lat);
        release_result(1'b0);
        checks++; if (y !== want)  begin errors++; $display("[TB] FAIL nogap_model got %h want %h", y, want); end
        checks++; if (y2 !== want) begin errors++; $display("[TB] FAIL gap_model got %h want %h", y2, want); end
    endtask

    task automatic test_random();
        logic [15:0] y, want;
        int lat;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 32; i++) ram[i] = 16'($urandom);
            for (int i = 0; i < N_IN; i++) begin
                xs[i] = 16'($urandom);
                if (t < 4) begin
                    ram[i] = 16'($signed(ram[i]) >>> 6);
                    xs[i]  = 16'($signed(xs[i]) >>> 6);
                end
            end
            want = model_y();
            start_eval(1'b0);
            stream_inputs(1'($urandom_range(0, 1)), N_IN);
            wait_result(y, lat);
            checks++; if (y !== want) begin errors++; $display("[TB] FAIL random_%0d got %h want %h", t, y, want); end
            release_result(1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] y, want;
        int lat;
        fill(16'h0100, 16'h0000, 16'h0100);
        // START held through the run and on the edge that leaves OUT.
        start_eval(1'b1);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== 16'h1B00) begin errors++; $display("[TB] FAIL start_held_y got %h want 1b00", y); end
        release_result(1'b1);
        @(negedge CLK);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("[TB] FAIL start_on_exit_busy got %b want 0", BUSY); end
        @(posedge CLK); #1;
        for (int i = 0; i < N_IN; i++) xs[i] = 16'($urandom_range(0, 255));
        want = model_y();
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== want) begin errors++; $display("[TB] FAIL back_to_back got %h want %h", y, want); end
        release_result(1'b0);
    endtask

    task automatic test_reset_midrun();
        logic [15:0] y;
        int lat;
        fill(16'h0200, 16'h0100, 16'h0100);
        start_eval(1'b0);
        stream_inputs(1'b0, 10);
        RST = 1'b1;
        #1;
        checks++;
        if ({BUSY, X_READY, W_EN, Y_VALID} !== 4'b0000 || W_ADDR !== 5'd0 || Y_DATA !== 16'h0) begin
            errors++;
            $display("[TB] FAIL midrun_reset got busy=%b xr=%b wen=%b yv=%b addr=%0d y=%h want all 0",
                     BUSY, X_READY, W_EN, Y_VALID, W_ADDR, Y_DATA);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        fill(16'h0100, 16'h0000, 16'h0100);
        start_eval(1'b0);
        stream_inputs(1'b0, N_IN);
        wait_result(y, lat);
        checks++; if (y !== 16'h1B00) begin errors++; $display("[TB] FAIL after_reset_y got %h want 1b00", y); end
        release_result(1'b0);
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; X_DATA = '0; X_VALID = 1'b0; Y_READY = 1'b0;
        for (int i = 0; i < 32; i++) ram[i] = 16'h0000;
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_ones();
        test_negative();
        test_saturation();
        test_bias_gaps();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
